sample_extend_arbiter: RTL

Shares one sign/zero-extension datapath between NUM_CH audio sample sources (ADC channels, test-signal generators) and delivers one widened sample per cycle to a downstream consumer. Each source presents a 24-bit container holding an 8-, 16- or 24-bit sample plus a signed flag. A round-robin scheduler picks one requester. The widened sample and its channel tag are registered behind a single-entry output buffer with valid/ready flow control.

---
 rtl/sample_arb_pkg.sv | 30 +++
 rtl/sample_extend_arbiter_if.sv | 36 +++
 rtl/sample_extend_arbiter_rr_pick.sv | 31 +++
 rtl/sample_extend_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/sample_arb_pkg.sv
// sample_arb_pkg: shared types and constants for sample_extend_arbiter.
// Holds the size code enum, output FSM states and container/counter widths.
package sample_arb_pkg;

    localparam int IN_WD  = 24;
    localparam int CNT_WD = 16;
    localparam int SZ_WD  = 2;

    typedef enum logic [1:0] {
        SZ8     = 2'b00,
        SZ16    = 2'b01,
        SZ24    = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Reserved code behaves as a full 24-bit field.
    function automatic int field_wd(size_e s);
        unique case (s)
            SZ8:     field_wd = 8;
            SZ16:    field_wd = 16;
            default: field_wd = 24;
        endcase
    endfunction

endpackage

// File: rtl/sample_extend_arbiter_if.sv
// sample_extend_arbiter_if: request side (NUM_CH sample sources), output side
// (valid/ready widened sample + channel tag), sticky error and grant counters.
interface sample_extend_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int OUT_WD = 32,
    parameter int CH_WD  = $clog2(NUM_CH)
);
    import sample_arb_pkg::*;

    logic [NUM_CH-1:0]        req_valid_i;
    logic [NUM_CH-1:0]        req_ready_o;
    logic [NUM_CH*IN_WD-1:0]  req_data_i;
    logic [NUM_CH*SZ_WD-1:0]  req_size_i;
    logic [NUM_CH-1:0]        req_signed_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [OUT_WD-1:0]        out_data_o;
    logic [CH_WD-1:0]         out_ch_o;
    logic                     err_o;
    logic [NUM_CH*CNT_WD-1:0] grant_cnt_o;

    modport master (
        output req_valid_i, req_data_i, req_size_i,
        output req_signed_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_data_o,
        input  out_ch_o, err_o, grant_cnt_o
    );

    modport slave (
        input  req_valid_i, req_data_i, req_size_i,
        input  req_signed_i, out_ready_i,
        output req_ready_o, out_valid_o, out_data_o,
        output out_ch_o, err_o, grant_cnt_o
    );

endinterface

// File: rtl/sample_extend_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; search starts at ptr+1.
// Ports: req (request vector), ptr (last winner), gnt (one-hot), idx (index).
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int CH_WD  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_WD-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_WD-1:0]  idx
);

    logic found;
    int   c;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = (int'(ptr) + k) % NUM_CH;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = CH_WD'(c);
            end
        end
    end

endmodule

// File: rtl/sample_extend_arbiter.sv
// sample_extend_arbiter: round-robin share of one sign/zero-extension path,
// one-entry valid/ready output buffer. Ports: clk_i, rst_i (sync, high), bus.
// Optional per-channel grant counters: define SAMPLE_ARB_GRANT_CNT_EN.
module sample_extend_arbiter
    import sample_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int OUT_WD = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    sample_extend_arbiter_if.slave  bus
);

    localparam int CH_WD = $clog2(NUM_CH);

    if (OUT_WD < IN_WD) begin : g_bad_out_wd
        $error("OUT_WD must be >= 24");
    end
    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
        $error("NUM_CH must be in 2..8");
    end

    out_state_e        state_q, state_d;
    logic [CH_WD-1:0]  rr_ptr_q;
    logic [OUT_WD-1:0] out_data_q;
    logic [CH_WD-1:0]  out_ch_q;
    logic              err_q;

    logic [NUM_CH-1:0] win_gnt;
    logic [CH_WD-1:0]  win_idx;
    logic [NUM_CH-1:0] req_ready;
    logic              load;
    logic              xfer;

    logic [IN_WD-1:0]  sel_data;
    size_e             sel_size;
    logic              sel_signed;
    logic [OUT_WD-1:0] data_x;
    logic [OUT_WD-1:0] ext_data;
    logic              fill;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_WD  (CH_WD)
    ) u_rr_pick (
        .req (bus.req_valid_i),
        .ptr (rr_ptr_q),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    assign load      = (state_q == EMPTY) || bus.out_ready_i;
    assign req_ready = (load && !rst_i) ? win_gnt : '0;
    assign xfer      = |req_ready;

    assign sel_data   = bus.req_data_i[int'(win_idx)*IN_WD +: IN_WD];
    assign sel_size   = size_e'(bus.req_size_i[int'(win_idx)*SZ_WD +: SZ_WD]);
    assign sel_signed = bus.req_signed_i[win_idx];
    assign data_x     = OUT_WD'(sel_data);

    // Bits above the selected field come from fill, not the container.
    always_comb begin
        ext_data = '0;
        fill     = 1'b0;
        unique case (sel_size)
            SZ8:     fill = sel_signed & sel_data[7];
            SZ16:    fill = sel_signed & sel_data[15];
            default: fill = sel_signed & sel_data[23];
        endcase
        for (int i = 0; i < OUT_WD; i++) begin
            ext_data[i] = (i < field_wd(sel_size)) ? data_x[i] : fill;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (!xfer && bus.out_ready_i) state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= CH_WD'(NUM_CH - 1);
            out_data_q <= '0;
            out_ch_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                rr_ptr_q   <= win_idx;
                out_data_q <= ext_data;
                out_ch_q   <= win_idx;
                if (sel_size == SZ_RSVD) err_q <= 1'b1;
            end
        end
    end

`ifdef SAMPLE_ARB_GRANT_CNT_EN
    for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
        logic [CNT_WD-1:0] cnt_q;
        always_ff @(posedge clk_i) begin
            if (rst_i) cnt_q <= '0;
            else if (req_ready[c]) cnt_q <= cnt_q + CNT_WD'(1);
        end
        assign bus.grant_cnt_o[c*CNT_WD +: CNT_WD] = cnt_q;
    end
`else
    assign bus.grant_cnt_o = '0;
`endif

    assign bus.req_ready_o = req_ready;
    assign bus.out_valid_o = (state_q == FULL);
    assign bus.out_data_o  = out_data_q;
    assign bus.out_ch_o    = out_ch_q;
    assign bus.err_o       = err_q;

endmodule
